fetch_queue_stage: RTL

//   Parametrised fetch stage: owns the fetch PC, issues one blocking imem read at a time and

---
 rtl/fetch_queue_stage.sv | 105 ++++++++++
 1 files changed

// File: rtl/fetch_queue_stage.sv
// rtl/fetch_queue_stage.sv - fetch PC owner with one-outstanding imem read and DEPTH-entry {pc, instr} queue
module fetch_queue_stage #(
    parameter int                 WORD_W   = 32,
    parameter int                 DEPTH    = 4,
    parameter logic [WORD_W-1:0]  RESET_PC = '0,
    parameter int                 PC_STEP  = 4
) (
    input  logic                     CLK,
    input  logic                     nRST,
    output logic                     imemREN,
    output logic [WORD_W-1:0]        imemaddr,
    input  logic                     ihit,
    input  logic [WORD_W-1:0]        imemload,
    input  logic                     pred_taken,
    input  logic [WORD_W-1:0]        pred_target,
    input  logic                     misprediction,
    input  logic [WORD_W-1:0]        correct_pc,
    input  logic                     freeze,
    input  logic                     halt,
    output logic                     instr_valid,
    output logic [WORD_W-1:0]        instr,
    output logic [WORD_W-1:0]        pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WORD_W-1:0] fetch_pc;
    logic [WORD_W-1:0] drop_addr;
    logic              busy;
    logic              drop;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [WORD_W-1:0] q_pc    [DEPTH];
    logic [WORD_W-1:0] q_instr [DEPTH];

    logic hit;
    logic enq;
    logic deq;

    // Gated by nRST so the request drops the instant reset asserts, not at the next edge.
    assign imemREN  = nRST && (busy || ((count < CW'(DEPTH)) && !halt));
    assign imemaddr = drop ? drop_addr : fetch_pc;

    assign hit = ihit && imemREN;
    assign enq = hit && !drop && !misprediction;
    assign deq = instr_valid && !freeze && !misprediction;

    assign instr_valid = (count != '0);
    assign instr       = instr_valid ? q_instr[rd_ptr] : '0;
    assign pc          = instr_valid ? q_pc[rd_ptr]    : '0;

    always_ff @(posedge CLK) begin
        if (enq) begin
            q_pc[wr_ptr]    <= fetch_pc;
            q_instr[wr_ptr] <= imemload;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            fetch_pc  <= RESET_PC;
            drop_addr <= '0;
            busy      <= 1'b0;
            drop      <= 1'b0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
        end else begin
            if (hit)
                busy <= 1'b0;
            else if (imemREN)
                busy <= 1'b1;

            if (misprediction) begin
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
                fetch_pc <= correct_pc;
                // An unanswered request must keep its address on the bus; its reply is discarded later.
                if (hit)
                    drop <= 1'b0;
                else if (imemREN && !drop) begin
                    drop      <= 1'b1;
                    drop_addr <= imemaddr;
                end
            end else begin
                if (hit && drop)
                    drop <= 1'b0;
                if (enq) begin
                    wr_ptr   <= wr_ptr + PW'(1);
                    fetch_pc <= pred_taken ? pred_target : fetch_pc + WORD_W'(PC_STEP);
                end
                if (deq)
                    rd_ptr <= rd_ptr + PW'(1);
                if (enq && !deq)
                    count <= count + CW'(1);
                else if (!enq && deq)
                    count <= count - CW'(1);
            end
        end
    end

endmodule
